// File: rtl/rate_spike_encoder.sv
// Rate-coded spike encoder: each accepted intensity sample yields a WINDOW-cycle
// Bernoulli spike train whose per-cycle probability is roughly level/2^W.
//
//  state | meaning
//  IDLE  | waiting for a sample, spike_out held low, LFSR frozen
//  RUN   | emitting one spike decision per cycle for the current window
module rate_spike_encoder #(
  parameter int          W      = 8,
  parameter int          WINDOW = 16,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         spike_out,
  output logic         busy,
  output logic         window_done
);

  // An all-zero seed would lock the LFSR, so it is swapped for the default.
  localparam logic [15:0]    SEED_EFF = (SEED == 16'h0) ? 16'hACE1 : SEED;
  localparam int             CW       = $clog2(WINDOW);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WINDOW - 1);
  localparam logic [15:0]    POLY     = 16'hB400;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [15:0]   lfsr, lfsr_nxt;
  logic [W-1:0]  level, level_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          spike_nxt, done_nxt;
  logic          last, accept, hit;
  logic [W-1:0]  r;

  assign r        = lfsr[15 -: W];
  assign last     = (state == RUN) && (cnt == CNT_LAST);
  assign in_ready = (state == IDLE) || last;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == RUN);
  // Full scale must spike every cycle, which r < level alone cannot reach.
  assign hit      = (level == {W{1'b1}}) || (r < level);

  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    level_nxt = level;
    cnt_nxt   = cnt;
    spike_nxt = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          level_nxt = in_data;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        spike_nxt = hit;
        lfsr_nxt  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? POLY : 16'h0);
        cnt_nxt   = cnt + CW'(1);
        if (last) begin
          done_nxt = 1'b1;
          cnt_nxt  = '0;
          if (accept) begin
            level_nxt = in_data;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lfsr        <= SEED_EFF;
      level       <= '0;
      cnt         <= '0;
      spike_out   <= 1'b0;
      window_done <= 1'b0;
    end else begin
      state       <= state_nxt;
      lfsr        <= lfsr_nxt;
      level       <= level_nxt;
      cnt         <= cnt_nxt;
      spike_out   <= spike_nxt;
      window_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_rate_spike_encoder.sv
// Self-checking bench for rate_spike_encoder: directed window vectors, corner
// sequences and randomized traffic against a remaining-cycles reference model.
module tb_rate_spike_encoder;

  localparam int          W      = 8;
  localparam int          WINDOW = 16;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, spike_out, busy, window_done;

  always #5 clk = ~clk;

  rate_spike_encoder #(.W(W), .WINDOW(WINDOW), .SEED(SEED)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .spike_out   (spike_out),
    .busy        (busy),
    .window_done (window_done)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: remaining spike cycles of the current window.
  logic [15:0]  m_lfsr;
  logic [W-1:0] m_level;
  int           m_rem;
  logic         m_spike, m_done;
  int           m_ones, d_ones, m_dones, d_dones;
  logic         seq_d [WINDOW];
  logic         seq_m [WINDOW];
  logic         seq3  [WINDOW];

  typedef struct {
    logic [W-1:0] data;
    int           exp_ones;   // -1: take the count from the reference model
    int           exp_dones;
  } vec_t;

  vec_t vecs [4];

  function automatic logic [15:0] galois(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic logic spike_of(input logic [W-1:0] lvl, input logic [15:0] s);
    int r;
    int l;
    r = int'(s >> (16 - W));
    l = int'(lvl);
    return (l == (1 << W) - 1) || (r < l);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lfsr  = SEED;
    m_level = '0;
    m_rem   = 0;
    m_spike = 1'b0;
    m_done  = 1'b0;
  endtask

  task automatic clear_counts();
    m_ones = 0; d_ones = 0; m_dones = 0; d_dones = 0;
  endtask

  // Called at a negedge; drives inputs, steps one clock, checks at next negedge.
  task automatic cycle(input logic v, input logic [W-1:0] d);
    logic m_ready, acc;
    in_valid = v;
    in_data  = d;
    #1;
    m_ready = (m_rem <= 1);
    chk("in_ready", int'(in_ready), int'(m_ready));
    acc = v && m_ready;
    @(posedge clk);
    if (m_rem > 0) begin
      m_spike = spike_of(m_level, m_lfsr);
      m_lfsr  = galois(m_lfsr);
      m_rem--;
      m_done  = (m_rem == 0);
    end else begin
      m_spike = 1'b0;
      m_done  = 1'b0;
    end
    if (acc) begin
      m_level = d;
      m_rem   = WINDOW;
    end
    @(negedge clk);
    chk("spike_out", int'(spike_out), int'(m_spike));
    chk("window_done", int'(window_done), int'(m_done));
    chk("busy", int'(busy), int'(m_rem > 0));
    m_ones  += int'(m_spike);
    d_ones  += int'(spike_out);
    m_dones += int'(m_done);
    d_dones += int'(window_done);
  endtask

  task automatic run_window(input logic [W-1:0] d);
    clear_counts();
    cycle(1'b1, d);
    for (int i = 0; i < WINDOW; i++) begin
      cycle(1'b0, '0);
      seq_d[i] = spike_out;
      seq_m[i] = m_spike;
    end
    cycle(1'b0, '0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_spike_out", int'(spike_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_window_done", int'(window_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{data: 8'h80, exp_ones: -1, exp_dones: 1};
    vecs[1] = '{data: 8'h00, exp_ones: 0,  exp_dones: 1};
    vecs[2] = '{data: 8'hFF, exp_ones: 16, exp_dones: 1};
    vecs[3] = '{data: 8'h01, exp_ones: -1, exp_dones: 1};

    model_reset();
    clear_counts();
    apply_reset();

    // Directed windows; the first one starts from the reset seed.
    for (int i = 0; i < 4; i++) begin
      run_window(vecs[i].data);
      chk($sformatf("vec%0d_ones", i), d_ones,
          (vecs[i].exp_ones < 0) ? m_ones : vecs[i].exp_ones);
      chk($sformatf("vec%0d_dones", i), d_dones, vecs[i].exp_dones);
      chk($sformatf("vec%0d_idle", i), int'(busy), 0);
      if (i == 0) begin
        for (int j = 0; j < WINDOW; j++) seq3[j] = seq_m[j];
      end
    end

    // Back-to-back: FF then 00 with in_valid held.
    clear_counts();
    cycle(1'b1, 8'hFF);
    for (int i = 0; i < WINDOW; i++) cycle(1'b1, 8'h00);
    chk("b2b_first_ones", d_ones, WINDOW);
    for (int i = 0; i < WINDOW; i++) cycle(1'b0, '0);
    chk("b2b_total_ones", d_ones, WINDOW);
    chk("b2b_dones", d_dones, 2);
    cycle(1'b0, '0);

    // Backpressure: a sample offered mid-window must be ignored.
    clear_counts();
    cycle(1'b1, 8'hFF);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0);
    cycle(1'b1, 8'h00);
    cycle(1'b1, 8'h00);
    for (int i = 0; i < WINDOW - 5; i++) cycle(1'b0, '0);
    chk("bp_ones", d_ones, WINDOW);
    chk("bp_dones", d_dones, 1);
    cycle(1'b0, '0);
    chk("bp_idle_busy", int'(busy), 0);

    // Reset at cnt=7 of a full-scale window, then replay the seed sequence.
    cycle(1'b1, 8'hFF);
    for (int i = 0; i < 7; i++) cycle(1'b0, '0);
    chk("pre_rst_spike", int'(spike_out), 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_spike_out", int'(spike_out), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_window_done", int'(window_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_window(8'h80);
    for (int j = 0; j < WINDOW; j++)
      chk($sformatf("replay_bit%0d", j), int'(seq_d[j]), int'(seq3[j]));

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic         v;
      logic [W-1:0] d;
      int           sel;
      v   = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 7);
      d   = (sel == 0) ? '0 : (sel == 1) ? {W{1'b1}} : W'($urandom);
      cycle(v, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
